// File: rtl/vector_writeback_unit.sv
// vector_writeback_unit: arbitrates ALU/load results into a small FIFO and drains
// one write per cycle into the vector register file's single write port.
// Keeps a pending-write scoreboard for RAW stalls. Results to hardwired registers
// (v0, v12..v15) finish their handshake but are dropped with a drop_err pulse.
// Optional feature: define VWB_BYPASS_EN to add a forwarding search
// (byp_raddr/byp_hit/byp_data) over queued entries and the rf_* output register.
module vector_writeback_unit #(
  parameter int DATA_WIDTH = 8,
  parameter int LANES      = 4,
  parameter int REG_COUNT  = 16,
  parameter int DEPTH      = 4,
  localparam int W  = DATA_WIDTH * LANES,
  localparam int AW = $clog2(REG_COUNT),
  localparam int PW = $clog2(DEPTH),
  localparam int CW = PW + 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 alu_valid,
  output logic                 alu_ready,
  input  logic [AW-1:0]        alu_rd,
  input  logic [W-1:0]         alu_data,
  input  logic                 ld_valid,
  output logic                 ld_ready,
  input  logic [AW-1:0]        ld_rd,
  input  logic [W-1:0]         ld_data,
  input  logic                 rsv_valid,
  input  logic [AW-1:0]        rsv_rd,
  output logic [REG_COUNT-1:0] busy_mask,
  output logic                 rf_we,
  output logic [AW-1:0]        rf_w_addr,
  output logic [W-1:0]         rf_w_data,
  output logic [CW-1:0]        fifo_count,
`ifdef VWB_BYPASS_EN
  input  logic [AW-1:0]        byp_raddr,
  output logic                 byp_hit,
  output logic [W-1:0]         byp_data,
`endif
  output logic                 drop_err
);

  function automatic logic f_hw(input logic [AW-1:0] rd);
    return (rd == '0) || (rd >= AW'(12));
  endfunction

  logic [AW-1:0] r_fifo_rd   [DEPTH];
  logic [W-1:0]  r_fifo_data [DEPTH];
  logic [PW-1:0] r_wptr, r_rptr;
  logic [CW-1:0] r_count;

  logic                 w_full, w_ld_acc, w_alu_acc, w_acc, w_hw, w_push, w_pop;
  logic [AW-1:0]        w_rd;
  logic [W-1:0]         w_data;
  logic [REG_COUNT-1:0] w_clr, w_set;

  // Load has fixed priority; full is judged on start-of-cycle occupancy only.
  assign w_full    = (r_count == CW'(DEPTH));
  assign ld_ready  = !w_full;
  assign alu_ready = !w_full && !ld_valid;
  assign w_ld_acc  = ld_valid && ld_ready;
  assign w_alu_acc = alu_valid && alu_ready;
  assign w_acc     = w_ld_acc || w_alu_acc;
  assign w_rd      = w_ld_acc ? ld_rd   : alu_rd;
  assign w_data    = w_ld_acc ? ld_data : alu_data;
  assign w_hw      = f_hw(w_rd);
  assign w_push    = w_acc && !w_hw;
  assign w_pop     = (r_count != '0);
  assign fifo_count = r_count;

  // Scoreboard: clear follows the cycle rf_we is seen; a same-cycle set wins.
  assign w_clr = rf_we ? (REG_COUNT'(1) << rf_w_addr) : '0;
  assign w_set = (rsv_valid && !f_hw(rsv_rd)) ? (REG_COUNT'(1) << rsv_rd) : '0;

  // FIFO storage; no reset needed since occupancy gates every read.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fifo_rd[r_wptr]   <= w_rd;
      r_fifo_data[r_wptr] <= w_data;
    end
  end

  // Pointers, occupancy, drain register, drop pulse and scoreboard.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr    <= '0;
      r_rptr    <= '0;
      r_count   <= '0;
      rf_we     <= 1'b0;
      rf_w_addr <= '0;
      rf_w_data <= '0;
      drop_err  <= 1'b0;
      busy_mask <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + PW'(1);
      if (w_pop)  r_rptr <= r_rptr + PW'(1);
      r_count  <= r_count + CW'(w_push) - CW'(w_pop);
      rf_we    <= w_pop;
      if (w_pop) begin
        rf_w_addr <= r_fifo_rd[r_rptr];
        rf_w_data <= r_fifo_data[r_rptr];
      end
      drop_err  <= w_acc && w_hw;
      busy_mask <= (busy_mask & ~w_clr) | w_set;
    end
  end

`ifdef VWB_BYPASS_EN
  // Forwarding search oldest-to-youngest so the youngest match is left standing.
  always_comb begin
    logic [PW-1:0] v_idx;
    v_idx    = '0;
    byp_hit  = rf_we && (rf_w_addr == byp_raddr);
    byp_data = rf_w_data;
    for (int i = 0; i < DEPTH; i++) begin
      v_idx = r_rptr + PW'(i);
      if ((CW'(i) < r_count) && (r_fifo_rd[v_idx] == byp_raddr)) begin
        byp_hit  = 1'b1;
        byp_data = r_fifo_data[v_idx];
      end
    end
    if (f_hw(byp_raddr)) byp_hit = 1'b0;
  end
`endif

endmodule

// File: tb/tb_vector_writeback_unit.sv
// Self-checking bench for vector_writeback_unit: directed scenarios plus random
// traffic, all compared against a queue-based behavioural model.
module tb_vector_writeback_unit;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        alu_valid, alu_ready, ld_valid, ld_ready, rsv_valid;
  logic [3:0]  alu_rd, ld_rd, rsv_rd, rf_w_addr;
  logic [31:0] alu_data, ld_data, rf_w_data;
  logic [15:0] busy_mask;
  logic        rf_we, drop_err;
  logic [2:0]  fifo_count;
`ifdef VWB_BYPASS_EN
  logic [3:0]  byp_raddr;
  logic        byp_hit;
  logic [31:0] byp_data;
`endif

  vector_writeback_unit #(.DATA_WIDTH(8), .LANES(4), .REG_COUNT(16), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd(alu_rd), .alu_data(alu_data),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_rd(ld_rd), .ld_data(ld_data),
    .rsv_valid(rsv_valid), .rsv_rd(rsv_rd), .busy_mask(busy_mask),
    .rf_we(rf_we), .rf_w_addr(rf_w_addr), .rf_w_data(rf_w_data),
    .fifo_count(fifo_count),
`ifdef VWB_BYPASS_EN
    .byp_raddr(byp_raddr), .byp_hit(byp_hit), .byp_data(byp_data),
`endif
    .drop_err(drop_err));

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  rd;
    logic [31:0] d;
  } ent_t;

  // Reference model state
  ent_t        q[$];
  logic        m_we, m_drop;
  logic [3:0]  m_addr;
  logic [31:0] m_data;
  logic [15:0] m_busy;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic is_hw(input logic [3:0] rd);
    return (rd == 4'd0) || (rd inside {4'd12, 4'd13, 4'd14, 4'd15});
  endfunction

  task automatic model_clear();
    q.delete();
    m_we = 0; m_drop = 0; m_addr = 0; m_data = 0; m_busy = 0;
  endtask

  // One clock: drive inputs, check every output against the model, advance the model.
  task automatic cycle(input logic lv, input logic [3:0] lrd, input logic [31:0] ldd,
                       input logic av, input logic [3:0] ard, input logic [31:0] ad,
                       input logic rv, input logic [3:0] rrd);
    logic full, lr, ar, acc;
    logic [3:0] rd;
    logic [31:0] d;
    ent_t e;
    @(negedge clk);
    ld_valid = lv; ld_rd = lrd; ld_data = ldd;
    alu_valid = av; alu_rd = ard; alu_data = ad;
    rsv_valid = rv; rsv_rd = rrd;
`ifdef VWB_BYPASS_EN
    byp_raddr = 4'($urandom_range(0, 15));
`endif
    #1;
    full = (q.size() == DEPTH);
    lr = !full;
    ar = !full && !lv;
    chk("rf_we", rf_we, m_we);
    chk("rf_w_addr", rf_w_addr, m_addr);
    chk("rf_w_data", rf_w_data, m_data);
    chk("busy_mask", busy_mask, m_busy);
    chk("fifo_count", fifo_count, q.size());
    chk("drop_err", drop_err, m_drop);
    chk("ld_ready", ld_ready, lr);
    chk("alu_ready", alu_ready, ar);
`ifdef VWB_BYPASS_EN
    begin
      logic h;
      logic [31:0] bd;
      h = 0; bd = 'x;
      for (int i = q.size() - 1; i >= 0 && !h; i--)
        if (q[i].rd == byp_raddr) begin h = 1; bd = q[i].d; end
      if (!h && m_we && m_addr == byp_raddr) begin h = 1; bd = m_data; end
      if (is_hw(byp_raddr)) h = 0;
      chk("byp_hit", byp_hit, h);
      if (h) chk("byp_data", byp_data, bd);
    end
`endif
    // model step
    acc = (lv && lr) || (av && ar);
    rd  = (lv && lr) ? lrd : ard;
    d   = (lv && lr) ? ldd : ad;
    if (m_we) m_busy[m_addr] = 1'b0;
    if (rv && !is_hw(rrd)) m_busy[rrd] = 1'b1;
    if (q.size() > 0) begin
      e = q.pop_front();
      m_we = 1; m_addr = e.rd; m_data = e.d;
    end else m_we = 0;
    m_drop = acc && is_hw(rd);
    if (acc && !is_hw(rd)) begin
      e.rd = rd; e.d = d;
      q.push_back(e);
    end
    @(posedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    rst_n = 0;
    ld_valid = 0; ld_rd = 0; ld_data = 0;
    alu_valid = 0; alu_rd = 0; alu_data = 0;
    rsv_valid = 0; rsv_rd = 0;
`ifdef VWB_BYPASS_EN
    byp_raddr = 0;
`endif
    model_clear();
    #12;
    chk("rst_rf_we", rf_we, 0);
    chk("rst_fifo_count", fifo_count, 0);
    chk("rst_busy", busy_mask, 0);
    chk("rst_drop", drop_err, 0);
    chk("rst_w_data", rf_w_data, 0);
    @(negedge clk) rst_n = 1;

    // ALU push v3 lands two cycles later, then rf_we drops
    cycle(0, 0, 0, 1, 4'd3, 32'hDEADBEEF, 0, 0);
    idle(3);

    // simultaneous ld/alu: load wins, ALU held and taken next cycle
    cycle(1, 4'd5, 32'h5555_0005, 1, 4'd6, 32'h6666_0006, 0, 0);
    cycle(0, 0, 0, 1, 4'd6, 32'h6666_0006, 0, 0);
    idle(3);

    // hardwired destinations are dropped
    cycle(0, 0, 0, 1, 4'd0, 32'h0000_0A0A, 0, 0);
    cycle(0, 0, 0, 1, 4'd13, 32'h1313_1313, 0, 0);
    idle(3);

    // scoreboard set wins over same-cycle clear
    cycle(0, 0, 0, 0, 0, 0, 1, 4'd7);
    cycle(0, 0, 0, 1, 4'd7, 32'h7777_0001, 0, 0);
    cycle(0, 0, 0, 0, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 0, 0, 1, 4'd7);        // rf_we for v7 visible here
    chk("busy7_kept", {31'd0, busy_mask[7]}, 1);
    cycle(1, 4'd7, 32'h7777_0002, 0, 0, 0, 0, 0);
    idle(3);
    chk("busy7_cleared", {31'd0, busy_mask[7]}, 0);

    // back-to-back pushes across pointer wrap
    for (int i = 0; i < 2 * DEPTH + 1; i++)
      cycle(i[0], 4'(1 + i % 11), $urandom, 1, 4'(2 + i % 9), $urandom, 0, 0);
    idle(3);

    // random traffic
    for (int i = 0; i < 400; i++)
      cycle(($urandom % 3) == 0, 4'($urandom), $urandom,
            ($urandom % 4) != 0, 4'($urandom), $urandom,
            ($urandom % 3) == 0, 4'($urandom));

    // mid-operation reset with writes in flight
    cycle(1, 4'd9, 32'h9999_0001, 0, 0, 0, 1, 4'd9);
    cycle(1, 4'd9, 32'h9999_0002, 0, 0, 0, 1, 4'd4);
    @(negedge clk);
    ld_valid = 0; alu_valid = 0; rsv_valid = 0;
    #2 rst_n = 0;
    #1;
    chk("mrst_fifo_count", fifo_count, 0);
    chk("mrst_rf_we", rf_we, 0);
    chk("mrst_busy", busy_mask, 0);
    model_clear();
    @(negedge clk) rst_n = 1;
    idle(4);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
